// File: rtl/logicnet_hgcal_pkg.sv
// Shared constants, state type and width helper for the HGCAL LogicNets input path.
package logicnet_hgcal_pkg;

    localparam int DEF_NUM_FEAT = 48;
    localparam int DEF_IN_BW    = 10;
    localparam int DEF_OUT_BW   = 2;
    localparam int DEF_SHIFT    = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

    function automatic int packed_width(input int num_feat, input int out_bw);
        return num_feat * out_bw;
    endfunction

endpackage

// File: rtl/feat_quant.sv
// Unsigned shift-and-saturate requantizer: q = min(d >> SHIFT, 2^OUT_BW-1).
module feat_quant #(
    parameter int IN_BW  = 10,
    parameter int OUT_BW = 2,
    parameter int SHIFT  = 8
) (
    input  logic [IN_BW-1:0]  d_i,
    output logic [OUT_BW-1:0] q_o
);

    localparam logic [IN_BW-1:0] MAX_Q = IN_BW'((1 << OUT_BW) - 1);

    logic [IN_BW-1:0] shifted;

    assign shifted = d_i >> SHIFT;
    assign q_o     = (shifted > MAX_Q) ? MAX_Q[OUT_BW-1:0] : shifted[OUT_BW-1:0];

endmodule

// File: rtl/hgcal_input_packer.sv
// Quantizes one raw cell per beat and packs NUM_FEAT of them into the layer-0 input vector.
// Optional s_last framing check is compiled in with HGCAL_INPUT_FRAME_CHECK_EN.
module hgcal_input_packer
    import logicnet_hgcal_pkg::*;
#(
    parameter int NUM_FEAT = DEF_NUM_FEAT,
    parameter int IN_BW    = DEF_IN_BW,
    parameter int OUT_BW   = DEF_OUT_BW,
    parameter int SHIFT    = DEF_SHIFT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [IN_BW-1:0]           s_data,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [NUM_FEAT*OUT_BW-1:0] m_data,
    output logic                       frame_err,
    output pack_state_e                dbg_state_o
);

    // Valid/ready: a beat moves on any rising edge where valid && ready are both high;
    // the source holds valid and data until then, and m_data/m_valid never change while
    // m_valid && !m_ready.
    localparam int VEC_W = packed_width(NUM_FEAT, OUT_BW);
    localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

    pack_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VEC_W-1:0] fill_q, fill_d;
    logic [VEC_W-1:0] m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;

    logic [OUT_BW-1:0] q;
    logic              accept;
    logic              out_free;
    logic              is_last_idx;
    logic              early_last;
    logic              missing_last;

    feat_quant #(
        .IN_BW (IN_BW),
        .OUT_BW(OUT_BW),
        .SHIFT (SHIFT)
    ) u_quant (
        .d_i(s_data),
        .q_o(q)
    );

    assign s_ready     = (state_q == FILL) && !rst;
    assign accept      = s_valid && s_ready;
    assign out_free    = !m_valid_q || m_ready;
    assign is_last_idx = (idx_q == LAST_IDX);

`ifdef HGCAL_INPUT_FRAME_CHECK_EN
    logic frame_err_q;

    assign early_last   = accept && s_last && !is_last_idx;
    assign missing_last = accept && !s_last && is_last_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else if (early_last || missing_last) begin
            frame_err_q <= 1'b1;
        end
    end

    assign frame_err = frame_err_q;
`else
    logic unused_s_last;

    assign unused_s_last = s_last;
    assign early_last    = 1'b0;
    assign missing_last  = 1'b0;
    assign frame_err     = 1'b0;
`endif

    always_comb begin
        fill_d = fill_q;
        if (accept) begin
            fill_d[int'(idx_q)*OUT_BW +: OUT_BW] = q;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q && !m_ready;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (early_last) begin
                        idx_d = '0;
                    end else if (is_last_idx) begin
                        // missing_last only flags the error; the frame still goes out.
                        idx_d = '0;
                        if (out_free) begin
                            m_data_d  = fill_d;
                            m_valid_d = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (m_valid_q && m_ready) begin
                    m_data_d  = fill_q;
                    m_valid_d = 1'b1;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            idx_q     <= '0;
            fill_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            fill_q    <= fill_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Directed scoreboard bench for hgcal_input_packer (default 48 x 10b -> 48 x 2b).
module tb_hgcal_input_packer;
    import logicnet_hgcal_pkg::*;

    localparam int NF = 48;
    localparam int VW = 96;

    localparam logic [VW-1:0] EXP_RAMP = {32'hAAAAAAAA, 32'h55555555, 32'h00000000};
    localparam logic [VW-1:0] EXP_ONES = {VW{1'b1}};
    localparam logic [VW-1:0] EXP_ZERO = '0;
    localparam logic [VW-1:0] EXP_TWOS = {24{4'hA}};
    localparam logic [VW-1:0] EXP_ALT  = {24{4'h1}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [9:0]    s_data = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [VW-1:0] m_data;
    logic          frame_err;
    pack_state_e   dbg_state;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int stall_cnt = 0;

    logic [VW-1:0] exp_q[$];
    int            hs_cycles[$];
    logic [9:0]    frame_d[NF];

    hgcal_input_packer dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .frame_err  (frame_err),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic expv);
        check(name, {{(VW-1){1'b0}}, act}, {{(VW-1){1'b0}}, expv});
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            hs_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_vector: got %h expected none", m_data);
            end else begin
                check("m_data", m_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the beat transferred.
    task automatic send_beat(input logic [9:0] d, input logic last);
        int budget;
        budget = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && budget < 300) begin
            @(posedge clk);
            #1;
            budget++;
            stall_cnt++;
        end
        if (budget >= 300) begin
            tests++;
            fails++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [VW-1:0] expv, input bit push, input int extra_last);
        if (push) exp_q.push_back(expv);
        for (int i = 0; i < NF; i++) begin
            send_beat(frame_d[i], (i == NF - 1) || (i == extra_last));
        end
    endtask

    task automatic set_ramp();
        for (int i = 0; i < NF; i++) frame_d[i] = 10'(i * 16);
    endtask

    task automatic set_const(input logic [9:0] v);
        for (int i = 0; i < NF; i++) frame_d[i] = v;
    endtask

    task automatic set_alt();
        for (int i = 0; i < NF; i++) frame_d[i] = (i % 2 == 0) ? 10'd300 : 10'd0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base_hs;

        // reset state
        wait_cycles(3);
        check_bit("rst_s_ready", s_ready, 1'b0);
        check_bit("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, EXP_ZERO);
        check_bit("rst_frame_err", frame_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ramp frame, 1-cycle latency after the last beat
        m_ready = 1'b1;
        set_ramp();
        exp_q.push_back(EXP_RAMP);
        for (int i = 0; i < NF - 1; i++) send_beat(frame_d[i], 1'b0);
        check_bit("ramp_no_early_valid", m_valid, 1'b0);
        send_beat(frame_d[NF-1], 1'b1);
        check_bit("ramp_latency", m_valid, 1'b1);
        check("ramp_direct", m_data, EXP_RAMP);
        check_bit("ramp_frame_err", frame_err, 1'b0);

        // saturation and floor
        set_const(10'd1023);
        send_frame(EXP_ONES, 1'b1, -1);
        set_const(10'd255);
        send_frame(EXP_ZERO, 1'b1, -1);
        wait_cycles(2);

        // backpressure: frame A held, frame B parks in HOLD
        m_ready = 1'b0;
        set_const(10'd512);
        send_frame(EXP_TWOS, 1'b1, -1);
        set_alt();
        send_frame(EXP_ALT, 1'b1, -1);
        check_bit("hold_s_ready", s_ready, 1'b0);
        check_bit("hold_state", dbg_state == HOLD, 1'b1);
        check("hold_m_data", m_data, EXP_TWOS);
        wait_cycles(3);
        check("hold_stable_data", m_data, EXP_TWOS);
        check_bit("hold_stable_valid", m_valid, 1'b1);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        check("swap_m_data", m_data, EXP_ALT);
        check_bit("swap_m_valid", m_valid, 1'b1);
        check_bit("swap_s_ready", s_ready, 1'b1);
        m_ready = 1'b1;
        wait_cycles(2);
        check_bit("drained_m_valid", m_valid, 1'b0);

        // back-to-back: three frames, no stalls, 48 cycles apart
        base_hs = hs_cycles.size();
        stall_cnt = 0;
        set_ramp();
        send_frame(EXP_RAMP, 1'b1, -1);
        set_const(10'd1023);
        send_frame(EXP_ONES, 1'b1, -1);
        set_alt();
        send_frame(EXP_ALT, 1'b1, -1);
        wait_cycles(3);
        check("b2b_stalls", VW'(stall_cnt), VW'(0));
        check("b2b_pulses", VW'(hs_cycles.size() - base_hs), VW'(3));
        if (hs_cycles.size() - base_hs == 3) begin
            check("b2b_gap1", VW'(hs_cycles[base_hs+1] - hs_cycles[base_hs]), VW'(48));
            check("b2b_gap2", VW'(hs_cycles[base_hs+2] - hs_cycles[base_hs+1]), VW'(48));
        end

        // async reset mid-frame
        m_ready = 1'b0;
        set_ramp();
        send_frame(EXP_RAMP, 1'b0, -1);
        check_bit("pre_rst_m_valid", m_valid, 1'b1);
        set_alt();
        for (int i = 0; i < 21; i++) send_beat(frame_d[i], 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_bit("async_rst_m_valid", m_valid, 1'b0);
        check_bit("async_rst_s_ready", s_ready, 1'b0);
        check("async_rst_m_data", m_data, EXP_ZERO);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        set_ramp();
        send_frame(EXP_RAMP, 1'b1, -1);
        wait_cycles(2);

`ifdef HGCAL_INPUT_FRAME_CHECK_EN
        set_alt();
        for (int i = 0; i < 11; i++) send_beat(frame_d[i], i == 10);
        check_bit("early_last_err", frame_err, 1'b1);
        wait_cycles(3);
        check_bit("early_last_no_out", m_valid, 1'b0);
        send_frame(EXP_ALT, 1'b1, -1);
        wait_cycles(2);
        check_bit("err_sticky", frame_err, 1'b1);
`else
        set_alt();
        send_frame(EXP_ALT, 1'b1, 10);
        wait_cycles(2);
        check_bit("s_last_ignored_err", frame_err, 1'b0);
`endif

        // drain the scoreboard
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drain", VW'(exp_q.size()), VW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hgcal_input_packer.md
Name: hgcal_input_packer

Overview:
- Upstream stage of the first LogicNets neuron layer in the HGCAL autoencoder.
- Accepts one raw sensor-cell value per beat over a valid/ready stream and quantizes it to OUT_BW bits by shift and saturate.
- Assembles NUM_FEAT quantized values into one packed vector.
- Holds the vector in an output register that drives the M0 input bus of the layer-0 neuron LUT bank, with a valid/ready handshake toward the downstream pipeline.

Parameters:
- NUM_FEAT, 48, features per frame (cells per sensor window).
- IN_BW, 10, raw input width, unsigned.
- OUT_BW, 2, quantized width per feature (matches layer-0 input bit width).
- SHIFT, 8, right-shift applied before saturation.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept a beat.
- s_data  in  IN_BW  raw feature value.
- s_last  in  1  marks final feature of a frame.
- m_valid  out  1  packed vector valid.
- m_ready  in  1  downstream accepts vector.
- m_data  out  NUM_FEAT*OUT_BW  packed vector; feature i at bits [i*OUT_BW +: OUT_BW].
- frame_err  out  1  sticky framing error.

Behaviour:
- Reset (async, while rst=1):
  - idx=0, state=FILL, fill buffer=0.
  - m_valid=0, m_data=0, frame_err=0.
  - s_ready=0 while rst is high.
- Quantize: q = min(s_data >> SHIFT, 2^OUT_BW-1), unsigned.
  - With defaults: 0..255→0, 256..511→1, 512..767→2, ≥768→3.
- Accept: a beat transfers when s_valid && s_ready. q is written to fill slot idx; idx increments.
- s_ready = (state==FILL) && !rst.
- State FILL:
  - Accepting the beat with idx==NUM_FEAT-1 completes the frame; idx wraps to 0.
  - If the output register is free (m_valid==0, or m_valid && m_ready in the same cycle), the complete vector, including the final beat, loads into m_data and m_valid=1 on the next edge. Latency from last beat to m_valid: 1 cycle.
  - Otherwise go to HOLD.
- State HOLD:
  - s_ready=0.
  - On the first cycle with m_valid && m_ready: load the fill buffer into m_data, keep m_valid=1, return to FILL.
- Output stability:
  - m_data and m_valid are stable while m_valid && !m_ready.
  - m_valid drops after a handshake unless a new vector loads on that same edge (back-to-back, no bubble).
- Throughput: one feature per cycle sustained when downstream is always ready; no idle cycle between frames.
- Fill buffer: not cleared between frames; every slot is overwritten before use.
- Reset mid-frame: the partial frame is discarded; the next accepted beat is feature 0.

Optional Feature:
- Macro: HGCAL_INPUT_FRAME_CHECK_EN.
- Defined:
  - s_last asserted on an accepted beat with idx!=NUM_FEAT-1: set frame_err, force idx=0, drop the partial frame (no output).
  - Beat at idx==NUM_FEAT-1 without s_last: set frame_err, but the frame is still emitted.
  - frame_err is cleared only by rst.
- Undefined: s_last is ignored; framing is by count only; frame_err is tied 0.

Decomposition:
- Shared package logicnet_hgcal_pkg holds:
  - constants NUM_FEAT, IN_BW, OUT_BW, SHIFT defaults;
  - the state enum type (FILL, HOLD);
  - a function for the packed-vector width.
- One natural combinational sub-module: feat_quant (shift + saturate, IN_BW→OUT_BW), reused by later per-layer requantizers.

Test Plan:
- Reset then stream 48 beats with s_data = i*16 (0..752), m_ready=1.
  - Expect m_valid one cycle after beat 47.
  - Expect feature i = min((i*16)>>8, 3): features 0–15=0, 16–31=1, 32–47=2.
  - Expect frame_err=0.
- Saturation: all beats s_data=1023.
  - Expect m_data = all ones (96'hFFFF...F).
  - Then all beats 255: expect m_data = 0.
- Backpressure: m_ready=0, stream two frames.
  - Second frame's last beat moves the block to HOLD; s_ready=0.
  - m_data stays equal to frame 1.
  - Raise m_ready for 1 cycle: m_data switches to frame 2 with m_valid still 1; s_ready returns to 1.
- Back-to-back: three continuous frames, m_ready=1.
  - Exactly 3 m_valid pulses, 48 cycles apart; no input stall.
- Async reset mid-frame: assert rst after beat 20.
  - m_valid=0 immediately; next 48 beats form a correct frame.
- With HGCAL_INPUT_FRAME_CHECK_EN: s_last on beat 10.
  - frame_err=1; no output for that partial frame.
  - Next 48 beats (last with s_last) emit normally; frame_err stays 1 until rst.
